aes_round_sched: RTL and testbench
==================================

# aes_round_sched

Round scheduler for the 128-bit block cipher datapath. It accepts one block request at a time over a valid/ready handshake and drives the key-schedule unit (aes_key_acc): load pulse, mode, and a monotonically stepped round index. For each round it captures the round key, issues one round to the external round-function datapath, waits for its completion, and returns the final state over a result handshake. A per-round watchdog ends the operation with an error if the datapath stalls.

## Interface
- NUM_ROUNDS, 8: rounds per block. Final round index is NUM_ROUNDS; valid range 1..15.
- TIMEOUT, 64: maximum WAIT cycles per round before abort. Valid range 1..255.
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high with req_valid
- req_key  in  256  key; bits [255:128] are used
- req_block  in  128  input block
- req_encdec  in  1  1 = encrypt, 0 = decrypt
- res_valid  out  1  result valid
- res_ready  in  1  result consumed
- res_block  out  128  output block
- res_err  out  1  watchdog abort flag, qualified by res_valid
- ks_key  out  256  key to the key unit
- ks_next  out  1  one-cycle load pulse
- ks_encdec  out  1  mode to the key unit
- ks_round  out  4  round index to the key unit
- ks_round_key  in  128  round key from the key unit
- rd_start  out  1  one-cycle round issue pulse
- rd_state  out  128  round input state
- rd_key  out  128  round key
- rd_last  out  1  high with rd_start on the final round
- rd_done  in  1  round complete
- rd_result  in  128  round output, valid with rd_done
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, LOAD, WARM, STEP, ISSUE, WAIT, OUT.
  - IDLE: req_ready = 1. On req_valid: latch key, block and mode into registers, then go to LOAD.
  - LOAD: ks_next = 1, ks_round = 0, then go to WARM.
  - WARM: state_reg <= block_reg ^ ks_round_key (round-0 whitening), r <= 1, then go to STEP.
  - STEP: ks_round = r (registered, so it changes on entry); rk_reg <= ks_round_key, then go to ISSUE.
  - ISSUE: rd_start = 1, rd_state = state_reg, rd_key = rk_reg, rd_last = (r == NUM_ROUNDS); clear the watchdog; go to WAIT.
  - WAIT: on rd_done, state_reg <= rd_result. If r == NUM_ROUNDS, go to OUT; otherwise r <= r+1 and go to STEP. Each WAIT cycle without rd_done increments the watchdog. When the watchdog reaches TIMEOUT, go to OUT with err = 1 and state_reg <= 0.
  - OUT: res_valid = 1, res_block = state_reg, res_err = err. On res_ready, clear err and go to IDLE.
- ks_encdec and ks_key are driven from the latched registers for the whole operation. The key unit performs the decrypt index remap; this block always counts 0..NUM_ROUNDS.
- ks_round changes only on STEP entry and on LOAD. After OUT it holds the final value until the next LOAD.
- rd_done is sampled only in WAIT; pulses in any other state are ignored.
- Requests arriving while busy see req_ready = 0 and are not dropped; the requester holds them.
- Reset (including mid-operation): state IDLE, r = 0. All outputs are 0 except req_ready = 1. Registers clear to 0.

## Timing
- Request accepted at clock edge 0. Cycle 1 is LOAD and cycle 2 is WARM.
- Each round takes STEP, ISSUE, then WAIT of at least 1 cycle.
- With rd_done asserted in the first WAIT cycle, res_valid rises in cycle 3·NUM_ROUNDS+3 (cycle 27 for the default NUM_ROUNDS = 8).
- The round key is captured one cycle after its round index is presented and is stable from that point.
- res_valid and res_block hold indefinitely while res_ready = 0.
- req_ready returns to 1 in the cycle after the OUT handshake. There is no back-to-back overlap.
- Watchdog: abort occurs after exactly TIMEOUT consecutive WAIT cycles without rd_done. If rd_done arrives in the same cycle the count reaches TIMEOUT, rd_done wins.

## Structure
- Shared package aes_ctrl_pkg holds:
  - the FSM state enum, 3 bits;
  - width constants: BLK_W = 128, KEY_W = 256, RND_W = 4.
- No sub-module is needed. The watchdog is an 8-bit counter inside this block.
- Top level instantiates this block next to aes_key_acc and the round datapath.

## Test plan
- Encrypt, instant datapath: key[255:128] = 0x000102…0F, block = 0. Expect ks_next for exactly 1 cycle, ks_round stepping 1..8, eight rd_start pulses with rd_last only on the eighth, and res_valid at cycle 27 matching the model.
- Decrypt, same key: expect ks_encdec = 0 held throughout, identical ks_round sequence, and the result matching the model inverse of the first scenario.
- Datapath latency randomised 1..10 per round, with res_ready held low for 5 cycles: expect rd_key stable during WAIT, res_block unchanged while stalled, and res_err = 0.
- rd_done never asserted in round 3 with TIMEOUT = 4: expect OUT 4 WAIT cycles after the third rd_start, res_err = 1, res_block = 0; the next request completes cleanly.
- req_valid held high through an operation, plus stray rd_done pulses in STEP and ISSUE: expect exactly one acceptance per operation and the stray pulses to have no effect.
- reset_n asserted low in round 5 WAIT: expect all outputs reset asynchronously and req_ready = 1; a fresh request after release produces the correct result.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and widths for the block-cipher control path.
package aes_ctrl_pkg;

    localparam int BLK_W  = 128;
    localparam int KEY_W  = 256;
    localparam int RND_W  = 4;
    localparam int WDOG_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WARM,
        ST_STEP,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT
    } sched_state_t;

endpackage

// File: rtl/aes_round_sched.sv
// Round scheduler: sequences the key unit and the external round datapath for one
// block at a time, with a per-round watchdog that aborts a stalled operation.
module aes_round_sched
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [KEY_W-1:0] req_key,
    input  logic [BLK_W-1:0] req_block,
    input  logic             req_encdec,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [BLK_W-1:0] res_block,
    output logic             res_err,
    output logic [KEY_W-1:0] ks_key,
    output logic             ks_next,
    output logic             ks_encdec,
    output logic [RND_W-1:0] ks_round,
    input  logic [BLK_W-1:0] ks_round_key,
    output logic             rd_start,
    output logic [BLK_W-1:0] rd_state,
    output logic [BLK_W-1:0] rd_key,
    output logic             rd_last,
    input  logic             rd_done,
    input  logic [BLK_W-1:0] rd_result,
    output logic             busy
);

    localparam logic [RND_W-1:0]  LAST_RND  = RND_W'(NUM_ROUNDS);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    sched_state_t      fsm_reg, fsm_next;
    logic [KEY_W-1:0]  key_reg, key_next;
    logic [BLK_W-1:0]  block_reg, block_next;
    logic              encdec_reg, encdec_next;
    logic [RND_W-1:0]  rnd_reg, rnd_next;
    logic [RND_W-1:0]  ks_round_reg, ks_round_next;
    logic [BLK_W-1:0]  data_reg, data_next;
    logic [BLK_W-1:0]  rk_reg, rk_next;
    logic              err_reg, err_next;
    logic [WDOG_W-1:0] wdog_reg, wdog_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_reg      <= ST_IDLE;
            key_reg      <= '0;
            block_reg    <= '0;
            encdec_reg   <= 1'b0;
            rnd_reg      <= '0;
            ks_round_reg <= '0;
            data_reg     <= '0;
            rk_reg       <= '0;
            err_reg      <= 1'b0;
            wdog_reg     <= '0;
        end else begin
            fsm_reg      <= fsm_next;
            key_reg      <= key_next;
            block_reg    <= block_next;
            encdec_reg   <= encdec_next;
            rnd_reg      <= rnd_next;
            ks_round_reg <= ks_round_next;
            data_reg     <= data_next;
            rk_reg       <= rk_next;
            err_reg      <= err_next;
            wdog_reg     <= wdog_next;
        end
    end

    always_comb begin
        fsm_next      = fsm_reg;
        key_next      = key_reg;
        block_next    = block_reg;
        encdec_next   = encdec_reg;
        rnd_next      = rnd_reg;
        ks_round_next = ks_round_reg;
        data_next     = data_reg;
        rk_next       = rk_reg;
        err_next      = err_reg;
        wdog_next     = wdog_reg;
        case (fsm_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    key_next      = req_key;
                    block_next    = req_block;
                    encdec_next   = req_encdec;
                    ks_round_next = '0;
                    fsm_next      = ST_LOAD;
                end
            end
            ST_LOAD: fsm_next = ST_WARM;
            ST_WARM: begin
                data_next     = block_reg ^ ks_round_key;
                rnd_next      = RND_W'(1);
                ks_round_next = RND_W'(1);
                fsm_next      = ST_STEP;
            end
            ST_STEP: begin
                rk_next  = ks_round_key;
                fsm_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                wdog_next = '0;
                fsm_next  = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion on the last permitted cycle still counts as success.
                if (rd_done) begin
                    data_next = rd_result;
                    if (rnd_reg == LAST_RND) begin
                        fsm_next = ST_OUT;
                    end else begin
                        rnd_next      = rnd_reg + RND_W'(1);
                        ks_round_next = rnd_reg + RND_W'(1);
                        fsm_next      = ST_STEP;
                    end
                end else if (wdog_reg == WDOG_LAST) begin
                    err_next  = 1'b1;
                    data_next = '0;
                    fsm_next  = ST_OUT;
                end else begin
                    wdog_next = wdog_reg + WDOG_W'(1);
                end
            end
            ST_OUT: begin
                if (res_ready) begin
                    err_next = 1'b0;
                    fsm_next = ST_IDLE;
                end
            end
            default: fsm_next = ST_IDLE;
        endcase
    end

    assign req_ready = (fsm_reg == ST_IDLE);
    assign busy      = (fsm_reg != ST_IDLE);
    assign ks_next   = (fsm_reg == ST_LOAD);
    assign ks_key    = key_reg;
    assign ks_encdec = encdec_reg;
    assign ks_round  = ks_round_reg;
    assign rd_start  = (fsm_reg == ST_ISSUE);
    assign rd_last   = (fsm_reg == ST_ISSUE) && (rnd_reg == LAST_RND);
    assign rd_state  = data_reg;
    assign rd_key    = rk_reg;
    assign res_valid = (fsm_reg == ST_OUT);
    assign res_block = data_reg;
    assign res_err   = err_reg;

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: toy key unit and round datapath, randomized latency,
// and a whole-block cipher model used to predict every result.
module tb_aes_round_sched;

    localparam int NR     = 8;
    localparam int WD_TMO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0, req_encdec = 1'b0, res_ready = 1'b0, rd_done = 1'b0;
    logic [255:0] req_key = '0;
    logic [127:0] req_block = '0, rd_result = '0;
    logic         sel = 1'b0;

    // per-instance outputs: a = default watchdog, b = short watchdog
    logic         req_ready_a, res_valid_a, res_err_a, ks_next_a, ks_encdec_a;
    logic         rd_start_a, rd_last_a, busy_a;
    logic [127:0] res_block_a, rd_state_a, rd_key_a, ks_round_key_a;
    logic [255:0] ks_key_a;
    logic [3:0]   ks_round_a;
    logic         req_ready_b, res_valid_b, res_err_b, ks_next_b, ks_encdec_b;
    logic         rd_start_b, rd_last_b, busy_b;
    logic [127:0] res_block_b, rd_state_b, rd_key_b, ks_round_key_b;
    logic [255:0] ks_key_b;
    logic [3:0]   ks_round_b;

    function automatic logic [127:0] rotl1(input logic [127:0] x);
        return {x[126:0], x[127]};
    endfunction

    function automatic logic [127:0] rotr1(input logic [127:0] x);
        return {x[0], x[127:1]};
    endfunction

    // Toy key unit: decrypt reverses the round index.
    function automatic logic [127:0] rk_model(input logic [127:0] k, input logic enc, input int i);
        int          idx;
        int          s;
        logic [3:0]  n;
        logic [127:0] r;
        idx = enc ? i : NR - i;
        s   = idx * 5;
        n   = 4'(idx);
        r   = (s == 0) ? k : ((k << s) | (k >> (128 - s)));
        return r ^ {16{n, 4'h9}};
    endfunction

    function automatic logic [127:0] round_model(input logic [127:0] s, input logic [127:0] k,
                                                 input logic enc);
        return enc ? (rotl1(s) ^ k) : (rotr1(s) ^ k);
    endfunction

    function automatic logic [127:0] cipher_model(input logic [255:0] key, input logic [127:0] blk,
                                                  input logic enc);
        logic [127:0] s;
        s = blk ^ rk_model(key[255:128], enc, 0);
        for (int i = 1; i <= NR; i++) s = round_model(s, rk_model(key[255:128], enc, i), enc);
        return s;
    endfunction

    assign ks_round_key_a = rk_model(ks_key_a[255:128], ks_encdec_a, int'(ks_round_a));
    assign ks_round_key_b = rk_model(ks_key_b[255:128], ks_encdec_b, int'(ks_round_b));

    aes_round_sched #(.NUM_ROUNDS(NR), .TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready_a), .req_key(req_key),
        .req_block(req_block), .req_encdec(req_encdec),
        .res_valid(res_valid_a), .res_ready(res_ready), .res_block(res_block_a), .res_err(res_err_a),
        .ks_key(ks_key_a), .ks_next(ks_next_a), .ks_encdec(ks_encdec_a), .ks_round(ks_round_a),
        .ks_round_key(ks_round_key_a),
        .rd_start(rd_start_a), .rd_state(rd_state_a), .rd_key(rd_key_a), .rd_last(rd_last_a),
        .rd_done(rd_done), .rd_result(rd_result), .busy(busy_a)
    );

    aes_round_sched #(.NUM_ROUNDS(NR), .TIMEOUT(WD_TMO)) dut_wd (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready_b), .req_key(req_key),
        .req_block(req_block), .req_encdec(req_encdec),
        .res_valid(res_valid_b), .res_ready(res_ready), .res_block(res_block_b), .res_err(res_err_b),
        .ks_key(ks_key_b), .ks_next(ks_next_b), .ks_encdec(ks_encdec_b), .ks_round(ks_round_b),
        .ks_round_key(ks_round_key_b),
        .rd_start(rd_start_b), .rd_state(rd_state_b), .rd_key(rd_key_b), .rd_last(rd_last_b),
        .rd_done(rd_done), .rd_result(rd_result), .busy(busy_b)
    );

    logic         req_ready, res_valid, res_err, ks_next, ks_encdec, rd_start, rd_last, busy;
    logic [127:0] res_block, rd_state, rd_key;
    logic [255:0] ks_key;
    logic [3:0]   ks_round;
    assign req_ready = sel ? req_ready_b : req_ready_a;
    assign res_valid = sel ? res_valid_b : res_valid_a;
    assign res_err   = sel ? res_err_b   : res_err_a;
    assign ks_next   = sel ? ks_next_b   : ks_next_a;
    assign ks_encdec = sel ? ks_encdec_b : ks_encdec_a;
    assign rd_start  = sel ? rd_start_b  : rd_start_a;
    assign rd_last   = sel ? rd_last_b   : rd_last_a;
    assign busy      = sel ? busy_b      : busy_a;
    assign res_block = sel ? res_block_b : res_block_a;
    assign rd_state  = sel ? rd_state_b  : rd_state_a;
    assign rd_key    = sel ? rd_key_b    : rd_key_a;
    assign ks_key    = sel ? ks_key_b    : ks_key_a;
    assign ks_round  = sel ? ks_round_b  : ks_round_a;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // stimulus controls written by the driver, read by the monitor
    int   lat [1:15];
    logic stray = 1'b0;
    logic cur_enc = 1'b0;

    // monitor/responder state
    int           ks_next_cnt = 0, start_cnt = 0, last_cnt = 0, last_at = 0;
    int           acc_cnt = 0, enc_bad = 0, key_bad = 0, wait_at_out = 0;
    logic [63:0]  seq_hist = '0;
    logic [3:0]   prev_ksr = '0;

    initial begin : monitor
        int           rnd;
        int           wcnt;
        int           wc;
        int           lat_cur;
        logic         pend;
        logic         rv_prev;
        logic [127:0] cap_state;
        logic [127:0] cap_key;
        rnd = 0; wcnt = 0; wc = 0; lat_cur = 0; pend = 1'b0; rv_prev = 1'b0;
        cap_state = '0; cap_key = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                pend = 1'b0; rd_done = 1'b0; rnd = 0; rv_prev = 1'b0;
            end else begin
                if (req_valid && req_ready) acc_cnt++;
                if (req_ready) rnd = 0;
                if (ks_next) ks_next_cnt++;
                if (busy && (ks_encdec !== cur_enc)) enc_bad++;
                if (ks_round !== prev_ksr) begin
                    seq_hist = {seq_hist[59:0], ks_round};
                    prev_ksr = ks_round;
                end
                if (res_valid && !rv_prev) wait_at_out = wc;
                rv_prev = res_valid;
                if (res_valid) pend = 1'b0;
                rd_done = 1'b0;
                if (stray && busy && !pend && !rd_start) begin
                    rd_done   = 1'b1;
                    rd_result = {$urandom, $urandom, $urandom, $urandom};
                end
                if (rd_start) begin
                    rnd++;
                    start_cnt++;
                    if (rd_last) begin last_cnt++; last_at = rnd; end
                    pend = 1'b1; wcnt = 0; wc = 0;
                    cap_state = rd_state; cap_key = rd_key;
                    lat_cur = (rnd <= 15) ? lat[rnd] : 1;
                    if (stray) begin
                        rd_done   = 1'b1;
                        rd_result = {$urandom, $urandom, $urandom, $urandom};
                    end
                end else if (pend) begin
                    wcnt++; wc++;
                    if (rd_key !== cap_key) key_bad++;
                    if (lat_cur != 0 && wcnt == lat_cur) begin
                        rd_done   = 1'b1;
                        rd_result = round_model(cap_state, cap_key, cur_enc);
                        pend      = 1'b0;
                    end
                end
            end
        end
    end

    task automatic set_lat(input int lo, input int hi);
        for (int i = 1; i <= 15; i++) lat[i] = $urandom_range(hi, lo);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_op(input logic [255:0] key, input logic [127:0] blk, input logic enc,
                          input int stall, input logic hold,
                          output logic [127:0] res, output logic err, output int cyc,
                          output int stall_bad);
        int guard;
        stall_bad = 0;
        @(negedge clk);
        req_key = key; req_block = blk; req_encdec = enc; cur_enc = enc;
        req_valid = 1'b1; res_ready = 1'b0;
        guard = 0;
        while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
        check("op_accept_wait", {255'd0, req_ready}, 256'd1);
        @(negedge clk);
        cyc = 1;
        if (!hold) req_valid = 1'b0;
        while (!res_valid && cyc < 2000) begin @(negedge clk); cyc++; end
        check("op_result_wait", {255'd0, res_valid}, 256'd1);
        res = res_block;
        err = res_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!res_valid || res_block !== res) stall_bad++;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        if (hold) req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [255:0] key;
        logic [127:0] res, ct, blk;
        logic         err, enc;
        int           cyc, sb;
        int           b_next, b_start, b_last, b_acc, b_enc, b_key;

        for (int i = 1; i <= 15; i++) lat[i] = 1;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", {255'd0, req_ready}, 256'd1);
        check("rst_ctrl", {248'd0, busy, res_valid, ks_next, rd_start, ks_round}, 256'd0);
        check("rst_data", {rd_state, res_block}, 256'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // encrypt, instant datapath
        key = {128'h000102030405060708090a0b0c0d0e0f, $urandom, $urandom, $urandom, $urandom};
        b_next = ks_next_cnt; b_start = start_cnt; b_last = last_cnt; b_acc = acc_cnt; b_enc = enc_bad;
        run_op(key, 128'd0, 1'b1, 0, 1'b0, res, err, cyc, sb);
        ct = res;
        check("enc_ks_next", 256'(ks_next_cnt - b_next), 256'd1);
        check("enc_starts", 256'(start_cnt - b_start), 256'(NR));
        check("enc_last_cnt", 256'(last_cnt - b_last), 256'd1);
        check("enc_last_at", 256'(last_at), 256'(NR));
        check("enc_ks_seq", {224'd0, seq_hist[31:0]}, 256'h12345678);
        check("enc_cycle", 256'(cyc), 256'(3 * NR + 3));
        check("enc_result", {128'd0, res}, {128'd0, cipher_model(key, 128'd0, 1'b1)});
        check("enc_err", {255'd0, err}, 256'd0);
        check("enc_mode_hold", 256'(enc_bad - b_enc), 256'd0);
        check("enc_accepts", 256'(acc_cnt - b_acc), 256'd1);

        // decrypt of the ciphertext must recover the zero block
        b_start = start_cnt; b_enc = enc_bad;
        run_op(key, ct, 1'b0, 0, 1'b0, res, err, cyc, sb);
        check("dec_result", {128'd0, res}, {128'd0, cipher_model(key, ct, 1'b0)});
        check("dec_inverse", {128'd0, res}, 256'd0);
        check("dec_ks_seq", {224'd0, seq_hist[31:0]}, 256'h12345678);
        check("dec_mode_hold", 256'(enc_bad - b_enc), 256'd0);
        check("dec_starts", 256'(start_cnt - b_start), 256'(NR));
        check("dec_cycle", 256'(cyc), 256'(3 * NR + 3));

        // random latency 1..10 with a stalled result consumer
        for (int t = 0; t < 3; t++) begin
            set_lat(1, 10);
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            blk = {$urandom, $urandom, $urandom, $urandom};
            enc = 1'($urandom_range(1, 0));
            b_key = key_bad;
            run_op(key, blk, enc, 5, 1'b0, res, err, cyc, sb);
            check($sformatf("lat%0d_result", t), {128'd0, res}, {128'd0, cipher_model(key, blk, enc)});
            check($sformatf("lat%0d_err", t), {255'd0, err}, 256'd0);
            check($sformatf("lat%0d_stall_hold", t), 256'(sb), 256'd0);
            check($sformatf("lat%0d_rd_key_stable", t), 256'(key_bad - b_key), 256'd0);
        end

        // request held high through the operation, stray rd_done outside WAIT
        set_lat(1, 3);
        stray = 1'b1;
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        blk = {$urandom, $urandom, $urandom, $urandom};
        b_acc = acc_cnt; b_start = start_cnt;
        run_op(key, blk, 1'b1, 0, 1'b1, res, err, cyc, sb);
        stray = 1'b0;
        check("hold_accepts", 256'(acc_cnt - b_acc), 256'd1);
        check("stray_result", {128'd0, res}, {128'd0, cipher_model(key, blk, 1'b1)});
        check("stray_starts", 256'(start_cnt - b_start), 256'(NR));

        // watchdog instance: round 3 never completes
        @(negedge clk);
        sel = 1'b1;
        do_reset();
        for (int i = 1; i <= 15; i++) lat[i] = 1;
        lat[2] = 2;
        lat[3] = 0;
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        blk = {$urandom, $urandom, $urandom, $urandom};
        b_start = start_cnt;
        run_op(key, blk, 1'b1, 2, 1'b0, res, err, cyc, sb);
        check("wd_err", {255'd0, err}, 256'd1);
        check("wd_block", {128'd0, res}, 256'd0);
        check("wd_wait_cycles", 256'(wait_at_out), 256'(WD_TMO));
        check("wd_starts", 256'(start_cnt - b_start), 256'd3);

        // completion on the final permitted WAIT cycle wins over the abort
        for (int i = 1; i <= 15; i++) lat[i] = 1;
        lat[3] = WD_TMO;
        run_op(key, blk, 1'b0, 0, 1'b0, res, err, cyc, sb);
        check("wd_edge_err", {255'd0, err}, 256'd0);
        check("wd_edge_result", {128'd0, res}, {128'd0, cipher_model(key, blk, 1'b0)});

        set_lat(1, 3);
        run_op(key, blk, 1'b1, 0, 1'b0, res, err, cyc, sb);
        check("wd_after_err", {255'd0, err}, 256'd0);
        check("wd_after_result", {128'd0, res}, {128'd0, cipher_model(key, blk, 1'b1)});

        // asynchronous reset in round 5 WAIT
        @(negedge clk);
        sel = 1'b0;
        do_reset();
        for (int i = 1; i <= 15; i++) lat[i] = 1;
        lat[5] = 4;
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        blk = {$urandom, $urandom, $urandom, $urandom};
        b_start = start_cnt;
        @(negedge clk);
        req_key = key; req_block = blk; req_encdec = 1'b1; cur_enc = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (start_cnt - b_start < 5 && cyc < 200) begin @(negedge clk); cyc++; end
        check("mid_round5_reached", 256'(start_cnt - b_start), 256'd5);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", {255'd0, req_ready}, 256'd1);
        check("mid_rst_ctrl", {246'd0, busy, res_valid, res_err, ks_next, ks_encdec, rd_start,
                               rd_last, ks_round}, 256'd0);
        check("mid_rst_data", {rd_state, rd_key}, 256'd0);
        check("mid_rst_key", ks_key, 256'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 15; i++) lat[i] = 1;
        run_op(key, blk, 1'b1, 0, 1'b0, res, err, cyc, sb);
        check("post_rst_result", {128'd0, res}, {128'd0, cipher_model(key, blk, 1'b1)});
        check("post_rst_cycle", 256'(cyc), 256'(3 * NR + 3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit exceeded");
    end

endmodule
